// File: rtl/stack_pointer_unit.sv
// Stack controller ahead of the data memory: owns the stack pointer and turns each
// PUSH/POP/CALL/RET into a single memory access, rejecting overflow and underflow.
module stack_pointer_unit #(
  parameter int   WIDTH       = 32,
  parameter int   STACK_TOP   = 255,
  parameter int   STACK_LIMIT = 224,
  parameter logic MEM_STORE   = 1'b0,
  parameter logic STACK_STORE = 1'b1,
  parameter logic ADDR_RF     = 1'b0,
  parameter logic ADDR_PC     = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic             hold,
  input  logic             flush,
  output logic             busy,
  output logic             op_done,
  output logic             op_err,
  output logic [WIDTH-1:0] stackPointer,
  output logic             stack_mem,
  output logic             address_data,
  output logic             ENW,
  output logic             ENR,
  output logic             sp_full,
  output logic             sp_empty,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;
  localparam logic [1:0] REJECT = 2'd3;

  localparam logic [1:0] OP_CALL = 2'b10;

  localparam logic [WIDTH-1:0] SP_TOP  = WIDTH'(STACK_TOP);
  localparam logic [WIDTH-1:0] SP_FULL = WIDTH'(STACK_LIMIT - 1);
  localparam logic [WIDTH-1:0] SP_ONE  = WIDTH'(1);

  // Handshake: op_valid/op are sampled only in IDLE; the requester drops op_valid in
  // the op_done/op_err cycle, and a request still high in the next IDLE cycle is a new op.
  logic [1:0]       state, state_n;
  logic [WIDTH-1:0] sp, sp_n;
  logic [1:0]       op_q, op_q_n;
  logic             in_access;

  assign sp_full   = (sp == SP_FULL);
  assign sp_empty  = (sp == SP_TOP);
  assign state_dbg = state;

  // op[0] separates reads (POP/RET) from writes (PUSH/CALL).
  always_comb begin
    state_n = state;
    sp_n    = sp;
    op_q_n  = op_q;
    if (flush) begin
      state_n = IDLE;
    end else if (!hold) begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            if ((!op[0] && sp_full) || (op[0] && sp_empty)) begin
              state_n = REJECT;
            end else begin
              state_n = ACCESS;
              op_q_n  = op;
            end
          end
        end
        ACCESS: state_n = UPDATE;
        UPDATE: begin
          state_n = IDLE;
          sp_n    = op_q[0] ? sp + SP_ONE : sp - SP_ONE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sp    <= SP_TOP;
      op_q  <= 2'b00;
    end else begin
      state <= state_n;
      sp    <= sp_n;
      op_q  <= op_q_n;
    end
  end

  // Outputs decode from registered state, so freezing the registers freezes them too.
  assign in_access    = (state == ACCESS);
  assign busy         = (state == ACCESS) || (state == UPDATE);
  assign op_done      = (state == UPDATE) && !flush;
  assign op_err       = (state == REJECT) && !flush;
  assign ENW          = in_access && !op_q[0];
  assign ENR          = in_access && op_q[0];
  assign stack_mem    = in_access ? STACK_STORE : MEM_STORE;
  assign address_data = (in_access && op_q == OP_CALL) ? ADDR_PC : ADDR_RF;
  // Reads address the last filled slot, one above the next free slot.
  assign stackPointer = (in_access && op_q[0]) ? sp + SP_ONE : sp;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed bench for stack_pointer_unit: each operation task lays out the expected
// per-cycle outputs from the operation's timeline; a compare process checks every cycle.
module tb_stack_pointer_unit;

  localparam int   TOP   = 255;
  localparam int   FULLV = 223;
  localparam logic MEM   = 1'b0;
  localparam logic STK   = 1'b1;
  localparam logic RF    = 1'b0;
  localparam logic PC    = 1'b1;
  localparam logic [1:0] PUSH = 2'b00, POP = 2'b01, CALL = 2'b10, RET = 2'b11;

  logic        clock, reset, op_valid, hold, flush;
  logic [1:0]  op;
  logic        busy, op_done, op_err, stack_mem, address_data, ENW, ENR, sp_full, sp_empty;
  logic [31:0] stackPointer;
  logic [1:0]  state_dbg;

  stack_pointer_unit dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op(op), .hold(hold), .flush(flush),
    .busy(busy), .op_done(op_done), .op_err(op_err), .stackPointer(stackPointer),
    .stack_mem(stack_mem), .address_data(address_data), .ENW(ENW), .ENR(ENR),
    .sp_full(sp_full), .sp_empty(sp_empty), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard: {busy,op_done,op_err,ENW,ENR,stack_mem,address_data,sp_full,sp_empty,stackPointer}
  logic [40:0] exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          msp;
  string       tag;

  function automatic logic [40:0] mk(input logic b, input logic d, input logic e,
                                     input logic w, input logic r, input logic sm,
                                     input logic ad, input int sp_reg, input int ptr);
    logic full, empty;
    full  = (sp_reg == FULLV);
    empty = (sp_reg == TOP);
    return {b, d, e, w, r, sm, ad, full, empty, 32'(ptr)};
  endfunction

  function automatic logic [40:0] idle_vec(input int sp_reg);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MEM, RF, sp_reg, sp_reg);
  endfunction

  always @(negedge clock) begin
    logic [40:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {busy, op_done, op_err, ENW, ENR, stack_mem, address_data, sp_full, sp_empty,
           stackPointer};
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got ctl=%b sp=%0d, want ctl=%b sp=%0d", tag,
                    a[40:32], a[31:0], e[40:32], e[31:0]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, want);
  endtask

  // driver tasks: inputs are changed 1 time unit after the rising edge
  task automatic cyc(input logic [40:0] e);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic do_op(input logic [1:0] o);
    logic wr;
    wr = !o[0];
    tag = $sformatf("op%0d@sp%0d", o, msp);
    op_valid = 1'b1;
    op = o;
    cyc(idle_vec(msp));
    op_valid = 1'b0;
    if ((wr && msp == FULLV) || (!wr && msp == TOP)) begin
      cyc(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, MEM, RF, msp, msp));
    end else begin
      cyc(mk(1'b1, 1'b0, 1'b0, wr, !wr, STK, (o == CALL) ? PC : RF, msp,
             wr ? msp : msp + 1));
      cyc(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MEM, RF, msp, msp));
      msp = wr ? msp - 1 : msp + 1;
    end
  endtask

  initial begin
    reset = 1'b0; op_valid = 1'b0; op = PUSH; hold = 1'b0; flush = 1'b0;
    msp = TOP;
    tag = "reset";
    @(posedge clock); #1;
    cyc(idle_vec(TOP));
    check("reset_sp_empty", 32'(sp_empty), 32'd1);
    reset = 1'b1;
    cyc(idle_vec(TOP));

    // single push, call/ret pair, pop back to empty
    do_op(PUSH);
    check("push_sp", stackPointer, 32'd254);
    do_op(CALL);
    check("call_sp", stackPointer, 32'd253);
    do_op(RET);
    check("ret_sp", stackPointer, 32'd254);
    do_op(POP);

    // underflow on an empty stack
    do_op(POP);
    do_op(RET);
    check("underflow_sp", stackPointer, 32'd255);

    // fill to capacity, then overflow
    for (int i = 0; i < 32; i++) do_op(PUSH);
    check("model_full_sp", 32'(msp), 32'd223);
    check("full_sp", stackPointer, 32'd223);
    check("full_flag", 32'(sp_full), 32'd1);
    do_op(PUSH);
    do_op(CALL);
    check("overflow_sp", stackPointer, 32'd223);
    do_op(POP);

    // flush during ACCESS: write already driven, no completion, SP kept
    tag = "flush_access";
    op_valid = 1'b1; op = PUSH;
    cyc(idle_vec(msp));
    op_valid = 1'b0; flush = 1'b1;
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, STK, RF, msp, msp));
    flush = 1'b0;
    cyc(idle_vec(msp));
    check("flush_access_sp", stackPointer, 32'd224);

    // hold for three cycles in UPDATE: op_done stays up, SP moves once
    tag = "hold_update";
    op_valid = 1'b1; op = PUSH;
    cyc(idle_vec(msp));
    op_valid = 1'b0;
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, STK, RF, msp, msp));
    hold = 1'b1;
    for (int i = 0; i < 3; i++) cyc(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MEM, RF, msp, msp));
    hold = 1'b0;
    cyc(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MEM, RF, msp, msp));
    msp = msp - 1;
    cyc(idle_vec(msp));
    check("hold_update_sp", stackPointer, 32'd223);

    // hold during a CALL access: write enable and PC select are held steady
    tag = "hold_access";
    do_op(POP);
    op_valid = 1'b1; op = CALL;
    cyc(idle_vec(msp));
    op_valid = 1'b0; hold = 1'b1;
    for (int i = 0; i < 2; i++) cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, STK, PC, msp, msp));
    hold = 1'b0;
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, STK, PC, msp, msp));
    cyc(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MEM, RF, msp, msp));
    msp = msp - 1;
    check("hold_access_sp", stackPointer, 32'd223);

    // flush during UPDATE of a POP: no op_done, SP unchanged
    tag = "flush_update";
    op_valid = 1'b1; op = POP;
    cyc(idle_vec(msp));
    op_valid = 1'b0;
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, STK, RF, msp, msp + 1));
    flush = 1'b1;
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, MEM, RF, msp, msp));
    flush = 1'b0;
    cyc(idle_vec(msp));
    check("flush_update_sp", stackPointer, 32'd223);

    // reset in the middle of a POP access
    tag = "reset_midop";
    op_valid = 1'b1; op = POP;
    cyc(idle_vec(msp));
    op_valid = 1'b0;
    reset = 1'b0;
    msp = TOP;
    cyc(idle_vec(msp));
    reset = 1'b1;
    cyc(idle_vec(msp));
    do_op(PUSH);
    check("post_reset_push_sp", stackPointer, 32'd254);

    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL leftover_expectations: got %0d, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
